fetch_sequencer: RTL and testbench

- Program-counter controller that sequences the combinational instruction ROM (A-bit address, W-bit instruction).
- Holds the PC and drives the ROM address.
- Advances sequentially or to an absolute branch target; honours a stall from the datapath.
- Detects the all-ones halt word and runs a Start/Done handshake with the testbench or top level.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/pc_next_sel.sv | 18 +
 rtl/fetch_sequencer.sv | 88 ++++++++
 tb/tb_fetch_sequencer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding, default widths and halt-word helper for the fetch sequencer.
package fetch_pkg;

   localparam int A_DEF  = 10;
   localparam int W_DEF  = 9;
   localparam int CW_DEF = 16;

   typedef enum logic [1:0] {IDLE, RUN, HALTED} fetch_state_t;

   // Wide enough for any practical instruction width; callers truncate to W.
   function automatic logic [63:0] halt_word(input int w);
      return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
   endfunction

endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: next-PC mux with halt > stall > branch > sequential priority.
module pc_next_sel #(
   parameter int A = 10
) (
   input  logic [A-1:0] pc,
   input  logic         branch_en,
   input  logic [A-1:0] branch_target,
   input  logic         stall,
   input  logic         halt_hit,
   output logic [A-1:0] pc_next,
   output logic         advance
);

   // A stalled branch is dropped; the datapath re-presents it after the stall.
   assign advance = !halt_hit && !stall;
   assign pc_next = !advance ? pc : branch_en ? branch_target : pc + 1'b1;

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC controller for a combinational instruction ROM with halt detection
// and a Start/Done handshake; counts retired instructions with saturation.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int A  = A_DEF,
   parameter int W  = W_DEF,
   parameter int CW = CW_DEF
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Start,
   input  logic [A-1:0]  StartAddr,
   input  logic          Stall,
   input  logic          BranchEn,
   input  logic [A-1:0]  BranchTarget,
   input  logic [W-1:0]  InstIn,
   output logic [A-1:0]  InstAddress,
   output logic          InstValid,
   output logic          Done,
   output logic [CW-1:0] InstCount
);

   localparam logic [W-1:0] HALT = W'(halt_word(W));

   fetch_state_t  state, state_next;
   logic [A-1:0]  pc, pc_next;
   logic [CW-1:0] count;
   logic          halt_hit, advance, load, running;

   assign running  = (state == RUN);
   assign halt_hit = running && (InstIn == HALT);

   pc_next_sel #(.A(A)) u_sel (
      .pc            (pc),
      .branch_en     (BranchEn),
      .branch_target (BranchTarget),
      .stall         (Stall),
      .halt_hit      (halt_hit),
      .pc_next       (pc_next),
      .advance       (advance)
   );

   always_comb begin
      state_next = state;
      load       = 1'b0;
      InstValid  = 1'b0;
      Done       = 1'b0;
      case (state)
         IDLE: begin
            load       = Start;
            state_next = Start ? RUN : IDLE;
         end
         RUN: begin
            InstValid  = !halt_hit;
            state_next = halt_hit ? HALTED : RUN;
         end
         HALTED: begin
            Done       = 1'b1;
            load       = Start;
            state_next = Start ? RUN : HALTED;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
         pc    <= '0;
         count <= '0;
      end else begin
         state <= state_next;
         if (load) begin
            pc    <= StartAddr;
            count <= '0;
         end else if (running) begin
            pc <= pc_next;
            if (advance && count != '1)
               count <= count + 1'b1;
         end
      end
   end

   assign InstAddress = pc;
   assign InstCount   = count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed checks of sequencing, branch, stall, wrap, restart,
// async reset and counter saturation against hand-computed values.
module tb_fetch_sequencer;

   logic        Clk = 1'b0;
   logic        Reset, Start, Stall, BranchEn;
   logic [9:0]  StartAddr, BranchTarget, InstAddress;
   logic [8:0]  InstIn;
   logic        InstValid, Done;
   logic [15:0] InstCount;
   logic [8:0]  rom [1024];

   logic        s_start;
   logic [9:0]  s_addr;
   logic        s_valid, s_done;
   logic [2:0]  s_count;

   int n_chk = 0;
   int n_fail = 0;

   always #5 Clk = ~Clk;

   assign InstIn = rom[InstAddress];

   fetch_sequencer dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr), .Stall(Stall),
      .BranchEn(BranchEn), .BranchTarget(BranchTarget), .InstIn(InstIn),
      .InstAddress(InstAddress), .InstValid(InstValid), .Done(Done), .InstCount(InstCount)
   );

   fetch_sequencer #(.CW(3)) dut_sat (
      .Clk(Clk), .Reset(Reset), .Start(s_start), .StartAddr(10'd0), .Stall(1'b0),
      .BranchEn(1'b0), .BranchTarget(10'd0), .InstIn(9'h000),
      .InstAddress(s_addr), .InstValid(s_valid), .Done(s_done), .InstCount(s_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge Clk) Reset = 1'b1;
      @(negedge Clk) Reset = 1'b0;
   endtask

   task automatic start_at(input logic [9:0] addr);
      Start = 1'b1;
      StartAddr = addr;
      step();
      Start = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) rom[i] = 9'(i % 256);
      rom[4] = 9'h1FF;
      Reset = 1'b1; Start = 1'b0; Stall = 1'b0; BranchEn = 1'b0;
      StartAddr = '0; BranchTarget = '0; s_start = 1'b0;
      #3;
      check("rst_addr",  32'(InstAddress), 32'd0);
      check("rst_done",  32'(Done), 32'd0);
      check("rst_valid", 32'(InstValid), 32'd0);
      check("rst_count", 32'(InstCount), 32'd0);
      @(negedge Clk) Reset = 1'b0;
      step();
      check("idle_addr",  32'(InstAddress), 32'd0);
      check("idle_valid", 32'(InstValid), 32'd0);

      // Sequential run into the halt word at address 4
      start_at(10'd0);
      check("seq_addr0",  32'(InstAddress), 32'd0);
      check("seq_valid0", 32'(InstValid), 32'd1);
      for (int i = 1; i <= 4; i++) begin
         step();
         check($sformatf("seq_addr%0d", i),  32'(InstAddress), 32'(i));
         check($sformatf("seq_valid%0d", i), 32'(InstValid), (i < 4) ? 32'd1 : 32'd0);
         check($sformatf("seq_done%0d", i),  32'(Done), 32'd0);
      end
      step();
      check("halt_done",  32'(Done), 32'd1);
      check("halt_addr",  32'(InstAddress), 32'd4);
      check("halt_count", 32'(InstCount), 32'd4);
      check("halt_valid", 32'(InstValid), 32'd0);
      step();
      check("halt_hold", 32'(Done), 32'd1);

      // Restart from HALTED, then Start in RUN is ignored
      start_at(10'd5);
      check("rs_done",  32'(Done), 32'd0);
      check("rs_addr",  32'(InstAddress), 32'd5);
      check("rs_count", 32'(InstCount), 32'd0);
      start_at(10'd0);
      check("run_start_addr",  32'(InstAddress), 32'd6);
      check("run_start_count", 32'(InstCount), 32'd1);

      // Stall for three cycles at PC=1
      do_reset();
      start_at(10'd1);
      Stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("stall_addr%0d", i),  32'(InstAddress), 32'd1);
         check($sformatf("stall_count%0d", i), 32'(InstCount), 32'd0);
      end
      Stall = 1'b0;
      step();
      check("unstall_addr",  32'(InstAddress), 32'd2);
      check("unstall_count", 32'(InstCount), 32'd1);

      // Branch at PC=2: stalled branch ignored, then taken
      BranchEn = 1'b1; BranchTarget = 10'd20; Stall = 1'b1;
      step();
      check("br_stall_addr",  32'(InstAddress), 32'd2);
      check("br_stall_count", 32'(InstCount), 32'd1);
      Stall = 1'b0;
      step();
      check("br_addr",  32'(InstAddress), 32'd20);
      check("br_count", 32'(InstCount), 32'd2);

      // Branch onto the halt word; halt wins over stall and branch
      BranchTarget = 10'd4;
      step();
      check("br_halt_addr",  32'(InstAddress), 32'd4);
      check("br_halt_valid", 32'(InstValid), 32'd0);
      check("br_halt_count", 32'(InstCount), 32'd3);
      Stall = 1'b1; BranchTarget = 10'd30;
      step();
      check("br_halt_done",  32'(Done), 32'd1);
      check("br_halt_hold",  32'(InstAddress), 32'd4);
      Stall = 1'b0; BranchEn = 1'b0;

      // Address wrap past the top of the ROM
      do_reset();
      start_at(10'h3FE);
      check("wrap_a", 32'(InstAddress), 32'h3FE);
      step();
      check("wrap_b", 32'(InstAddress), 32'h3FF);
      step();
      check("wrap_c",     32'(InstAddress), 32'h000);
      check("wrap_count", 32'(InstCount), 32'd2);

      // Asynchronous reset in the middle of a cycle while running
      do_reset();
      start_at(10'd7);
      check("ar_pre_addr",  32'(InstAddress), 32'd7);
      check("ar_pre_valid", 32'(InstValid), 32'd1);
      #2 Reset = 1'b1;
      #1;
      check("ar_addr",  32'(InstAddress), 32'd0);
      check("ar_done",  32'(Done), 32'd0);
      check("ar_valid", 32'(InstValid), 32'd0);
      @(negedge Clk) Reset = 1'b0;
      step();
      check("ar_idle_addr",  32'(InstAddress), 32'd0);
      check("ar_idle_valid", 32'(InstValid), 32'd0);
      check("ar_idle_count", 32'(InstCount), 32'd0);

      // Saturating counter on a 3-bit instance
      s_start = 1'b1;
      step();
      s_start = 1'b0;
      repeat (6) step();
      check("sat_count6", 32'(s_count), 32'd6);
      step();
      check("sat_count7", 32'(s_count), 32'd7);
      repeat (5) step();
      check("sat_hold",  32'(s_count), 32'd7);
      check("sat_addr",  32'(s_addr), 32'd12);
      check("sat_valid", 32'(s_valid), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
